// File: rtl/chi_intf_pkg.sv
// ---------------------------------------------------------------------------
// chi_intf: shared CHI link-layer definitions.
//   reqflit_t     request-channel flit payload (REQ channel, RN-F -> HN-F)
//   CHI_MAX_LCRD  architectural ceiling on link-layer credits a receiver grants
// ---------------------------------------------------------------------------
package chi_intf;

  localparam int CHI_MAX_LCRD = 15;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    logic [5:0]  opcode;
    logic [2:0]  size;
    logic [43:0] addr;
  } reqflit_t;

endpackage

// File: rtl/rnf_txreq_if.sv
// ---------------------------------------------------------------------------
// rnf_txreq_if: bundle of the TXREQ transmitter's handshake and link signals.
//   req_valid / req_ready / req_flit       protocol layer -> transmitter
//   txreqflit / txreqflitv / txreqflitpend transmitter -> HN-F RXREQ
//   txreqlcrdv                             HN-F RXREQ -> transmitter (credit return)
// Modports:
//   master  the transmitter (rnf_txreq)
//   slave   its environment (protocol layer + link partner)
// ---------------------------------------------------------------------------
interface rnf_txreq_if;
  import chi_intf::*;

  logic     req_valid;
  logic     req_ready;
  reqflit_t req_flit;
  reqflit_t txreqflit;
  logic     txreqflitv;
  logic     txreqflitpend;
  logic     txreqlcrdv;

  modport master (
    input  req_valid, req_flit, txreqlcrdv,
    output req_ready, txreqflit, txreqflitv, txreqflitpend
  );

  modport slave (
    output req_valid, req_flit, txreqlcrdv,
    input  req_ready, txreqflit, txreqflitv, txreqflitpend
  );

endinterface

// File: rtl/rnf_txreq_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo: single-clock FIFO of DEPTH entries of type T (DEPTH a power of 2).
//   clock   rising-edge clock
//   reset   synchronous, active-low; empties the FIFO
//   push    write wdata (ignored while full)
//   wdata   entry to write
//   pop     advance the read pointer (ignored while empty)
//   rdata   current head entry (valid while !empty)
//   full    all DEPTH entries occupied
//   empty   no entries held
// No bypass: an entry is readable only from the cycle after it is written.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; occupancy decides what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rnf_txreq.sv
// ---------------------------------------------------------------------------
// rnf_txreq: RN-F CHI TXREQ link-layer transmitter.
// Buffers request flits from the protocol layer and sends one per cycle to
// the HN-F RXREQ receiver whenever an L-credit is held. FLITPEND is raised
// in the launch cycle, FLITV and the flit follow one cycle later.
//   clock        rising-edge clock
//   reset        synchronous, active-low
//   txreq        rnf_txreq_if.master: req_* from protocol layer, txreq* link
//   crd_cnt      L-credits currently held
//   err_crd_ovf  sticky: credit returned while already holding MAX_CRD
// ---------------------------------------------------------------------------
module rnf_txreq
  import chi_intf::*;
#(
  parameter  int FIFO_DEPTH = 4,
  parameter  int MAX_CRD    = CHI_MAX_LCRD,
  localparam int CRD_W      = $clog2(MAX_CRD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  rnf_txreq_if.master      txreq,
  output logic [CRD_W-1:0] crd_cnt,
  output logic             err_crd_ovf
);

  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     launch;
  logic     out_of_reset;
  reqflit_t head;

  // Holds req_ready low for the cycle following a reset edge.
  assign txreq.req_ready = out_of_reset && !fifo_full;
  assign push            = txreq.req_valid && txreq.req_ready;

  // Launch looks only at registered state; a credit arriving this cycle
  // cannot be spent until it has been counted.
  assign launch              = !fifo_empty && (crd_cnt != '0);
  assign txreq.txreqflitpend = launch;

  sync_fifo #(
    .T     (reqflit_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (txreq.req_flit),
    .pop   (launch),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Credit counter. Return and spend in the same cycle cancel out; a return
  // at the ceiling is dropped and flagged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      crd_cnt     <= '0;
      err_crd_ovf <= 1'b0;
    end else begin
      case ({txreq.txreqlcrdv, launch})
        2'b10: begin
          if (crd_cnt == CRD_W'(MAX_CRD)) err_crd_ovf <= 1'b1;
          else                            crd_cnt     <= crd_cnt + 1'b1;
        end
        2'b01:   crd_cnt <= crd_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Link output registers; the flit bus keeps its last value when idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_of_reset     <= 1'b0;
      txreq.txreqflitv <= 1'b0;
      txreq.txreqflit  <= '0;
    end else begin
      out_of_reset     <= 1'b1;
      txreq.txreqflitv <= launch;
      if (launch) txreq.txreqflit <= head;
    end
  end

endmodule

// File: tb/tb_rnf_txreq.sv
`timescale 1ns/1ps
module tb_rnf_txreq;
  import chi_intf::*;

  localparam int DEPTH = 4;
  localparam int MAXC  = 15;
  localparam int NVEC  = 19;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] crd_cnt;
  logic       err_crd_ovf;

  rnf_txreq_if txreq ();

  rnf_txreq #(.FIFO_DEPTH(DEPTH), .MAX_CRD(MAXC)) dut (
    .clock       (clock),
    .reset       (reset),
    .txreq       (txreq),
    .crd_cnt     (crd_cnt),
    .err_crd_ovf (err_crd_ovf)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic reqflit_t mkflit(input logic [7:0] id);
    reqflit_t f;
    f        = '0;
    f.txnid  = id;
    f.opcode = 6'h04;
    f.srcid  = 7'h02;
    f.tgtid  = 7'h10;
    f.addr   = {28'h0, id, 8'h40};
    return f;
  endfunction

  function automatic reqflit_t rndflit();
    logic [95:0] r;
    reqflit_t    f;
    r = {$urandom(), $urandom(), $urandom()};
    f = r[$bits(reqflit_t)-1:0];
    return f;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst, v;
    logic [7:0] id;
    bit         lc, chk;
    bit         e_rdy, e_pend, e_flitv;
    logic [7:0] e_id;
    logic [3:0] e_crd;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mkvec(bit rst, bit v, logic [7:0] id, bit lc, bit chk,
                                 bit r, bit p, bit fv, logic [7:0] eid, logic [3:0] c);
    vec_t t;
    t.rst = rst; t.v = v; t.id = id; t.lc = lc; t.chk = chk;
    t.e_rdy = r; t.e_pend = p; t.e_flitv = fv; t.e_id = eid; t.e_crd = c;
    return t;
  endfunction

  // ---------------- behavioural reference model ----------------
  // A queue of accepted flits and an integer credit balance; outputs are
  // derived from the rules: pend = buffered & credit held, flit one cycle on.
  reqflit_t m_q [$];
  int       m_crd;
  bit       m_vld, m_ovf, m_rdy, m_known;
  reqflit_t m_flit;

  task automatic model_edge(input bit rst, input bit v, input reqflit_t f, input bit lc);
    bit launch, push;
    if (!rst) begin
      m_q.delete();
      m_crd = 0; m_vld = 0; m_flit = '0; m_ovf = 0; m_rdy = 0; m_known = 1;
    end else if (m_known) begin
      launch = (m_q.size() > 0) && (m_crd > 0);
      push   = v && m_rdy && (m_q.size() < DEPTH);
      m_vld  = launch;
      if (launch) m_flit = m_q.pop_front();
      if (push)   m_q.push_back(f);
      m_crd = m_crd + int'(lc) - int'(launch);
      if (m_crd > MAXC) begin
        m_crd = MAXC;
        m_ovf = 1;
      end
      m_rdy = 1;
    end
  endtask

  bit obs_ready, obs_flitv;

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input bit rst, input bit v, input reqflit_t f, input bit lc);
    reset = rst; txreq.req_valid = v; txreq.req_flit = f; txreq.txreqlcrdv = lc;
    @(negedge clock);
    obs_ready = txreq.req_ready;
    obs_flitv = txreq.txreqflitv;
    if (m_known) begin
      check("req_ready",     txreq.req_ready,     m_rdy && (m_q.size() < DEPTH));
      check("txreqflitpend", txreq.txreqflitpend, (m_q.size() > 0) && (m_crd > 0));
      check("txreqflitv",    txreq.txreqflitv,    m_vld);
      check("txreqflit",     txreq.txreqflit,     m_flit);
      check("crd_cnt",       crd_cnt,             m_crd[3:0]);
      check("err_crd_ovf",   err_crd_ovf,         m_ovf);
    end
    @(posedge clock);
    model_edge(rst, v, f, lc);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int nvalid, run, maxrun, k;
    bit accepted;
    reqflit_t f5;

    txreq.req_valid = 0; txreq.req_flit = '0; txreq.txreqlcrdv = 0;
    m_known = 0;

    //          rst v  id     lc chk rdy pend flitv eid    crd
    tbl[0]  = mkvec(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    tbl[1]  = mkvec(1, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0);
    tbl[2]  = mkvec(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 1);
    tbl[3]  = mkvec(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 2);
    tbl[4]  = mkvec(1, 1, 8'h05, 0, 1, 1, 0, 0, 8'h00, 3);
    tbl[5]  = mkvec(1, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 3);
    tbl[6]  = mkvec(1, 0, 8'h00, 0, 1, 1, 0, 1, 8'h05, 2);
    tbl[7]  = mkvec(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h05, 2);
    tbl[8]  = mkvec(0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h05, 2);
    tbl[9]  = mkvec(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0);
    tbl[10] = mkvec(1, 1, 8'h11, 0, 1, 1, 0, 0, 8'h00, 0);
    tbl[11] = mkvec(1, 1, 8'h12, 0, 1, 1, 0, 0, 8'h00, 0);
    tbl[12] = mkvec(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0);
    tbl[13] = mkvec(1, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1);
    tbl[14] = mkvec(1, 0, 8'h00, 0, 1, 1, 0, 1, 8'h11, 0);
    tbl[15] = mkvec(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h11, 0);
    tbl[16] = mkvec(1, 0, 8'h00, 0, 1, 1, 1, 0, 8'h11, 1);
    tbl[17] = mkvec(1, 0, 8'h00, 0, 1, 1, 0, 1, 8'h12, 0);
    tbl[18] = mkvec(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h12, 0);

    for (int i = 0; i < NVEC; i++) begin
      reset = tbl[i].rst; txreq.req_valid = tbl[i].v;
      txreq.req_flit = mkflit(tbl[i].id); txreq.txreqlcrdv = tbl[i].lc;
      @(negedge clock);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d req_ready", i),   txreq.req_ready,       tbl[i].e_rdy);
        check($sformatf("vec%0d pend", i),        txreq.txreqflitpend,   tbl[i].e_pend);
        check($sformatf("vec%0d flitv", i),       txreq.txreqflitv,      tbl[i].e_flitv);
        check($sformatf("vec%0d txnid", i),       txreq.txreqflit.txnid, tbl[i].e_id);
        check($sformatf("vec%0d crd_cnt", i),     crd_cnt,               tbl[i].e_crd);
        check($sformatf("vec%0d err_crd_ovf", i), err_crd_ovf,           1'b0);
      end
      @(posedge clock);
      #1;
    end

    // ---- back-to-back burst with 15 credits ----
    step(0, 0, '0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, '0, 1);
    check("b2b_crd_before", crd_cnt, 15);
    nvalid = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, i < 4, mkflit(8'h30 + 8'(i)), 0);
      if (obs_flitv) begin nvalid++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    check("b2b_flitv_cycles", nvalid, 4);
    check("b2b_flitv_run", maxrun, 4);
    check("b2b_crd_after", crd_cnt, 11);

    // ---- fill FIFO with no credits, hold the fifth request ----
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, mkflit(8'h40 + 8'(i)), 0);
    check("full_ready_low", txreq.req_ready, 0);
    f5 = mkflit(8'h44);
    step(1, 1, f5, 0);
    step(1, 1, f5, 0);
    accepted = 0;
    k = 0;
    while (k < 10 && !accepted) begin
      step(1, 1, f5, k == 0);
      if (obs_ready) accepted = 1;
      k++;
    end
    check("full_fifth_accepted", accepted, 1);
    check("full_fifth_wait", k, 3);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, '0, 0);

    // ---- simultaneous return and launch, then overflow ----
    step(0, 0, '0, 0);
    step(1, 0, '0, 1);
    step(1, 1, mkflit(8'h50), 0);
    step(1, 0, '0, 1);
    check("simul_crd", crd_cnt, 1);
    check("simul_flitv", txreq.txreqflitv, 1);
    for (int i = 0; i < 14; i++) step(1, 0, '0, 1);
    check("ovf_crd_at_max", crd_cnt, 15);
    check("ovf_err_before", err_crd_ovf, 0);
    step(1, 0, '0, 1);
    check("ovf_crd_held", crd_cnt, 15);
    check("ovf_err_set", err_crd_ovf, 1);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0);
    check("ovf_err_sticky", err_crd_ovf, 1);

    // ---- reset in the middle of a burst ----
    step(0, 0, '0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, mkflit(8'h60 + 8'(i)), 0);
    check("rstmid_flitv_before", txreq.txreqflitv, 1);
    step(0, 1, mkflit(8'h64), 1);
    check("rstmid_flitv", txreq.txreqflitv, 0);
    check("rstmid_pend", txreq.txreqflitpend, 0);
    check("rstmid_crd", crd_cnt, 0);
    check("rstmid_ready_low", txreq.req_ready, 0);
    step(1, 0, '0, 0);
    check("rstmid_ready_high", txreq.req_ready, 1);
    nvalid = 0;
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, '0, 0);
      if (obs_flitv) nvalid++;
    end
    check("rstmid_fifo_empty", nvalid, 0);

    // ---- randomized traffic against the reference model ----
    step(0, 0, '0, 0);
    for (int i = 0; i < 3000; i++) begin
      int lc_pct;
      lc_pct = 20 + 20 * (i / 1000);
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 99) < 60,
           rndflit(),
           $urandom_range(0, 99) < lc_pct);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
